// File: rtl/mod_pkg.sv
// Shared constants, FSM state encoding and scrambler helper for the bit packer.
package mod_pkg;

  localparam int WORDS_PER_SYM = 25;
  localparam int BITS_PER_SYM  = 800;
  localparam int WORD_IDX_W    = 5;

  localparam logic [WORD_IDX_W-1:0] LAST_WORD_IDX = WORD_IDX_W'(WORDS_PER_SYM - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PACK = 2'd1,
    PAD  = 2'd2
  } state_e;

  // x^7 + x^4 + 1 : feedback taken from s[6] and s[3]
  localparam logic [6:0] SCR_POLY = 7'b100_1000;
  localparam logic [6:0] SCR_SEED = 7'h7F;

  // Scramble one byte LSB-first; returns {next LFSR state, scrambled byte}
  function automatic logic [14:0] scr_byte(input logic [6:0] seed, input logic [7:0] din);
    logic [6:0] s;
    logic [7:0] dout;
    logic       fb;
    s    = seed;
    dout = '0;
    fb   = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb      = ^(s & SCR_POLY);
      dout[i] = din[i] ^ fb;
      s       = {s[5:0], fb};
    end
    return {s, dout};
  endfunction

endpackage

// File: rtl/mod_scrambler7.sv
// 802.11 style x^7+x^4+1 scrambler. Processes up to four bytes per clock; each
// enabled byte consumes eight LFSR steps, lower byte lanes first, so the
// keystream stays continuous whether bytes arrive one at a time or as a padded word.
module mod_scrambler7
  import mod_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        load_i,
  input  logic        step_i,
  input  logic [3:0]  byte_en_i,
  input  logic [31:0] din_i,
  output logic [31:0] dout_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;

  // Walk the enabled byte lanes through the LFSR, starting from the seed when reloading
  always_comb begin
    logic [14:0] res;
    res    = '0;
    lfsr_d = load_i ? SCR_SEED : lfsr_q;
    dout_o = din_i;
    for (int k = 0; k < 4; k++) begin
      if (byte_en_i[k]) begin
        res              = scr_byte(lfsr_d, din_i[8*k +: 8]);
        dout_o[8*k +: 8] = res[7:0];
        lfsr_d           = res[14:8];
      end
    end
  end

  // LFSR state register; only advances when a scrambled byte is actually consumed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= SCR_SEED;
    end else if (clr_i) begin
      lfsr_q <= SCR_SEED;
    end else if (step_i) begin
      lfsr_q <= lfsr_d;
    end
  end

endmodule

// File: rtl/mod_bit_packer.sv
// Byte stream to 32-bit word packer feeding the subcarrier modulator FIFO.
// Packs LSB-first and pads every packet to a whole symbol of 25 words so the
// modulator never starves mid-symbol. Define MOD_SCRAMBLE_EN to scramble
// payload and pad bits with the x^7+x^4+1 scrambler.
module mod_bit_packer
  import mod_pkg::*;
#(
  parameter int C_S_AXIS_TDATA_WIDTH = 8,
  parameter int C_M_AXIS_TDATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            reset_mod,
  input  logic [C_S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic                            s_axis_tlast,
  output logic [C_M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [15:0]                     sym_count,
  output logic [1:0]                      st
);

  state_e                state_q, state_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [WORD_IDX_W-1:0] word_idx_q, word_idx_d;
  logic [31:0]           data_q, data_d;
  logic [31:0]           out_data_q;
  logic                  out_valid_q;
  logic                  out_last_q;
  logic [15:0]           sym_q;

  logic                  s_ready, s_acc, out_room, drain;
  logic                  commit;
  logic [31:0]           commit_word;
  logic                  scr_load, scr_step;
  logic [3:0]            scr_en;
  logic [31:0]           scr_din, scr_dout;

  assign drain    = out_valid_q & m_axis_tready;
  assign out_room = ~out_valid_q | m_axis_tready;
  assign s_ready  = ((state_q == IDLE) || (state_q == PACK))
                  && !(out_valid_q && !m_axis_tready && (byte_idx_q == 2'd3))
                  && !rst && !reset_mod;
  assign s_acc    = s_axis_tvalid & s_ready;

  assign s_axis_tready = s_ready;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tlast  = out_last_q;
  assign sym_count     = sym_q;
  assign st            = state_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else if (reset_mod) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a tlast that does not land exactly on the symbol's last byte forces padding
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (s_acc) state_d = s_axis_tlast ? PAD : PACK;
      PACK: if (s_acc && s_axis_tlast)
              state_d = ((byte_idx_q == 2'd3) && (word_idx_q == LAST_WORD_IDX)) ? IDLE : PAD;
      PAD:  if (out_room && (word_idx_q == LAST_WORD_IDX)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs to the scrambler: one payload byte on accept, or every unfilled lane while padding
  always_comb begin
    scr_load = 1'b0;
    scr_step = 1'b0;
    scr_en   = '0;
    scr_din  = '0;
    if (s_acc) begin
      scr_load = (state_q == IDLE);
      scr_step = 1'b1;
      scr_en   = 4'b0001;
      scr_din  = {24'h0, s_axis_tdata};
    end else if ((state_q == PAD) && out_room) begin
      scr_step = 1'b1;
      for (int k = 0; k < 4; k++) begin
        scr_en[k] = (2'(k) >= byte_idx_q);
      end
    end
  end

`ifdef MOD_SCRAMBLE_EN
  mod_scrambler7 u_scrambler (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (reset_mod),
    .load_i    (scr_load),
    .step_i    (scr_step),
    .byte_en_i (scr_en),
    .din_i     (scr_din),
    .dout_o    (scr_dout)
  );
`else
  logic unused_scr;
  assign unused_scr = ^{scr_load, scr_step, scr_en};
  assign scr_dout   = scr_din;
`endif

  // Packing datapath: place bytes into lanes and decide when a word is committed
  always_comb begin
    byte_idx_d  = byte_idx_q;
    word_idx_d  = word_idx_q;
    data_d      = data_q;
    commit      = 1'b0;
    commit_word = '0;
    if (s_acc) begin
      data_d[{byte_idx_q, 3'b000} +: 8] = scr_dout[7:0];
      byte_idx_d = byte_idx_q + 2'd1;
      if (byte_idx_q == 2'd3) begin
        commit      = 1'b1;
        commit_word = data_d;
        word_idx_d  = (word_idx_q == LAST_WORD_IDX) ? '0 : word_idx_q + 1'b1;
      end
    end else if ((state_q == PAD) && out_room) begin
      commit     = 1'b1;
      byte_idx_d = 2'd0;
      word_idx_d = (word_idx_q == LAST_WORD_IDX) ? '0 : word_idx_q + 1'b1;
      for (int k = 0; k < 4; k++) begin
        if (2'(k) < byte_idx_q) commit_word[8*k +: 8] = data_q[8*k +: 8];
        else                    commit_word[8*k +: 8] = scr_dout[8*k +: 8];
      end
    end
  end

  // Packing registers: lane buffer and byte/word position within the symbol
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      byte_idx_q <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
    end else if (reset_mod) begin
      byte_idx_q <= '0;
      word_idx_q <= '0;
      data_q     <= '0;
    end else begin
      byte_idx_q <= byte_idx_d;
      word_idx_q <= word_idx_d;
      data_q     <= data_d;
    end
  end

  // Single-entry output register; a commit may replace a word draining in the same clock
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sym_q       <= '0;
    end else if (reset_mod) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      sym_q       <= '0;
    end else begin
      if (commit) begin
        out_valid_q <= 1'b1;
        out_data_q  <= commit_word;
        out_last_q  <= (word_idx_q == LAST_WORD_IDX);
      end else if (drain) begin
        out_valid_q <= 1'b0;
      end
      if (drain && out_last_q) begin
        sym_q <= sym_q + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_mod_bit_packer.sv
// Self-checking bench for mod_bit_packer. Expected words come from a packet
// level model: pad the byte stream to whole 100-byte symbols, optionally
// scramble the bit stream, then cut it into little-endian 32-bit words.
module tb_mod_bit_packer;

  logic        clk;
  logic        rst;
  logic        reset_mod;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] sym_count;
  logic [1:0]  st;

  int          assertCount = 0;
  int          failCount   = 0;
  logic [31:0] expData[$];
  bit          expLast[$];
  int          expSym      = 0;
  int          wordCount   = 0;
  int          readyMode   = 0;
  bit          abortPkt    = 0;
  logic [7:0]  pkt[$];

  mod_bit_packer dut (
    .clk           (clk),
    .rst           (rst),
    .reset_mod     (reset_mod),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tlast  (m_axis_tlast),
    .sym_count     (sym_count),
    .st            (st)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference model: turn the packet in pkt into the expected word stream
  task automatic modelPacket(input bit padSym);
    int         total;
    logic [31:0] w;
    logic [7:0]  b;
`ifdef MOD_SCRAMBLE_EN
    logic [6:0]  s;
    logic        fb;
    s  = 7'h7F;
    fb = 1'b0;
`endif
    total = pkt.size();
    if (padSym) total = ((total + 99) / 100) * 100;
    w = '0;
    for (int i = 0; i < total; i++) begin
      b = (i < pkt.size()) ? pkt[i] : 8'h00;
`ifdef MOD_SCRAMBLE_EN
      for (int j = 0; j < 8; j++) begin
        fb   = s[6] ^ s[3];
        b[j] = b[j] ^ fb;
        s    = {s[5:0], fb};
      end
`endif
      w[8*(i%4) +: 8] = b;
      if ((i % 4) == 3) begin
        expData.push_back(w);
        expLast.push_back(((i / 4) % 25) == 24);
        w = '0;
      end
    end
  endtask

  // Downstream ready pattern: 0 always ready, 1 random, 2 stalled
  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(negedge clk);
      case (readyMode)
        0:       m_axis_tready = 1'b1;
        1:       m_axis_tready = ($urandom_range(0, 99) < 70);
        default: m_axis_tready = 1'b0;
      endcase
    end
  end

  // Output monitor: scoreboard compare on each handshake plus hold-while-stalled checks
  initial begin : monitor
    bit          prevStall;
    logic [31:0] prevData;
    logic        prevLast;
    bit          lastFlag;
    prevStall = 1'b0;
    prevData  = '0;
    prevLast  = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (rst || reset_mod) begin
        prevStall = 1'b0;
      end else begin
        if (prevStall) begin
          checkOutput("hold tvalid", 32'(m_axis_tvalid), 32'd1);
          checkOutput("hold tdata", m_axis_tdata, prevData);
          checkOutput("hold tlast", 32'(m_axis_tlast), 32'(prevLast));
        end
        if (m_axis_tvalid && m_axis_tready) begin
          wordCount++;
          if (expData.size() == 0) begin
            checkOutput("unexpected word", 32'(m_axis_tvalid), 32'd0);
          end else begin
            lastFlag = expLast.pop_front();
            checkOutput("word tdata", m_axis_tdata, expData.pop_front());
            checkOutput("word tlast", 32'(m_axis_tlast), 32'(lastFlag));
            checkOutput("sym_count at word", 32'(sym_count), 32'(expSym));
            if (lastFlag) expSym = (expSym + 1) % 65536;
          end
        end
        prevStall = m_axis_tvalid && !m_axis_tready;
        prevData  = m_axis_tdata;
        prevLast  = m_axis_tlast;
      end
    end
  end

  // Offer one byte from a negedge and return on the negedge after it is accepted
  task automatic sendByte(input logic [7:0] b, input logic last);
    bit hs;
    int guard;
    s_axis_tdata  = b;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    hs    = 1'b0;
    guard = 0;
    while (!hs && !abortPkt) begin
      #4;
      hs = s_axis_tready;
      @(negedge clk);
      guard++;
      if (!hs && guard > 3000) begin
        checkOutput("s_axis_tready timeout", 32'(s_axis_tready), 32'd1);
        abortPkt = 1'b1;
      end
    end
  endtask

  // Stream the bytes in pkt with random idle gaps
  task automatic applyStimulus(input int gapPct, input bit withLast);
    for (int i = 0; i < pkt.size() && !abortPkt; i++) begin
      while ($urandom_range(0, 99) < gapPct) begin
        s_axis_tvalid = 1'b0;
        @(negedge clk);
      end
      sendByte(pkt[i], withLast && (i == pkt.size() - 1));
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  // Wait until every expected word has left the DUT, then confirm the symbol count
  task automatic waitDrain();
    int guard = 0;
    while ((expData.size() != 0 || m_axis_tvalid) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("words outstanding", 32'(expData.size()), 32'd0);
    checkOutput("sym_count", 32'(sym_count), 32'(expSym));
  endtask

  task automatic fillPkt(input int len, input logic [7:0] value, input bit randomData);
    pkt.delete();
    for (int i = 0; i < len; i++) pkt.push_back(randomData ? 8'($urandom) : value);
  endtask

  initial begin
    int lens[8];
    int startCount;
    rst           = 1'b0;
    reset_mod     = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("reset tdata", m_axis_tdata, 32'd0);
    checkOutput("reset tlast", 32'(m_axis_tlast), 32'd0);
    checkOutput("reset sym_count", 32'(sym_count), 32'd0);
    checkOutput("reset st", 32'(st), 32'd0);
    checkOutput("reset s_tready", 32'(s_axis_tready), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #4;
    checkOutput("idle s_tready", 32'(s_axis_tready), 32'd1);
    checkOutput("idle st", 32'(st), 32'd0);
    @(negedge clk);

    // One full symbol of zeros ends exactly on the symbol boundary
    fillPkt(100, 8'h00, 1'b0);
    modelPacket(1'b1);
    applyStimulus(0, 1'b1);
    waitDrain();
    checkOutput("t1 sym_count", 32'(sym_count), 32'd1);

    // Four bytes: word visible the cycle after the fourth byte
`ifdef MOD_SCRAMBLE_EN
    fillPkt(4, 8'h00, 1'b0);
`else
    pkt.delete();
    for (int i = 1; i <= 4; i++) pkt.push_back(8'(i));
`endif
    modelPacket(1'b1);
    for (int i = 0; i < 4; i++) sendByte(pkt[i], i == 3);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #4;
    checkOutput("latency tvalid", 32'(m_axis_tvalid), 32'd1);
`ifdef MOD_SCRAMBLE_EN
    checkOutput("scrambled word0", m_axis_tdata, 32'h40934F70);
`else
    checkOutput("packed word0", m_axis_tdata, 32'h04030201);
`endif
    @(negedge clk);
    waitDrain();
    checkOutput("t2 sym_count", 32'(sym_count), 32'd2);

    // Six bytes: second word is a partial word with zero upper lanes
    fillPkt(6, 8'hAA, 1'b0);
    modelPacket(1'b1);
    applyStimulus(0, 1'b1);
    waitDrain();

    // Downstream stall: input must stop once a full word is waiting behind the output
    readyMode = 2;
    @(negedge clk);
    fillPkt(12, 8'h00, 1'b1);
    modelPacket(1'b1);
    for (int i = 0; i < 7; i++) sendByte(pkt[i], 1'b0);
    s_axis_tdata  = pkt[7];
    s_axis_tvalid = 1'b1;
    #4;
    checkOutput("stall s_tready", 32'(s_axis_tready), 32'd0);
    checkOutput("stall tvalid", 32'(m_axis_tvalid), 32'd1);
    repeat (10) @(negedge clk);
    readyMode = 0;
    for (int i = 7; i < 12; i++) sendByte(pkt[i], i == 11);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    waitDrain();

    // Random packets around symbol boundaries with random backpressure
    lens = '{1, 99, 100, 101, 200, 0, 0, 0};
    for (int p = 5; p < 8; p++) lens[p] = $urandom_range(2, 260);
    readyMode = 1;
    for (int p = 0; p < 8; p++) begin
      fillPkt(lens[p], 8'h00, 1'b1);
      modelPacket(1'b1);
      applyStimulus(20, 1'b1);
    end
    waitDrain();
    readyMode = 0;
    @(negedge clk);

    // Synchronous soft clear in the middle of a packet
    fillPkt(50, 8'h00, 1'b1);
    modelPacket(1'b0);
    applyStimulus(0, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("rm words outstanding", 32'(expData.size()), 32'd0);
    checkOutput("rm st before", 32'(st), 32'd1);
    reset_mod = 1'b1;
    @(negedge clk);
    reset_mod = 1'b0;
    #4;
    checkOutput("rm st", 32'(st), 32'd0);
    checkOutput("rm tvalid", 32'(m_axis_tvalid), 32'd0);
    checkOutput("rm sym_count", 32'(sym_count), 32'd0);
    expSym = 0;
    @(negedge clk);

    // Asynchronous reset after ten words of a long packet
    fillPkt(200, 8'h00, 1'b1);
    modelPacket(1'b1);
    startCount = wordCount;
    abortPkt   = 1'b0;
    fork
      applyStimulus(0, 1'b1);
      begin : rstThread
        int g = 0;
        while (wordCount < startCount + 10 && g < 3000) begin
          @(negedge clk);
          g++;
        end
        #2;
        rst      = 1'b1;
        abortPkt = 1'b1;
        #1;
        checkOutput("rst tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst tdata", m_axis_tdata, 32'd0);
        checkOutput("rst tlast", 32'(m_axis_tlast), 32'd0);
        checkOutput("rst sym_count", 32'(sym_count), 32'd0);
        checkOutput("rst st", 32'(st), 32'd0);
      end
    join
    expData.delete();
    expLast.delete();
    expSym   = 0;
    abortPkt = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pkt.delete();
    for (int i = 1; i <= 4; i++) pkt.push_back(8'(i));
    modelPacket(1'b1);
    applyStimulus(0, 1'b1);
    waitDrain();
    checkOutput("t6 sym_count", 32'(sym_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
